// File: rtl/elevator_scan_controller.sv
// Purpose: single-cab SCAN elevator controller; latches floor calls and serves them sweeping one direction at a time.
// Latency: a call for the cab's own floor opens the door on the next cycle; travel takes STEP_TICKS cycles per floor.
// Backpressure: none; calls are latched on any cycle and held until served at their floor or cleared by reset.
//
// Ports:
//   clk, rst       : single clock, synchronous active-high reset
//   call_in        : per-floor call request, bit i = floor i (pulse or level)
//   current_floor  : registered cab position, always within 0..NUM_FLOORS-1
//   pending        : registered mask of latched, not yet served calls
//   moving_up/moving_down/door_open/idle : one-hot decode of the controller state
module elevator_scan_controller #(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = 4,
  parameter int STEP_TICKS = 10000000,
  parameter int DOOR_TICKS = 20000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_in,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic                  idle
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DOOR = 2'd3;

  // One counter width covers both timers; it only ever reaches TICKS-1.
  localparam int MAX_TICKS = (STEP_TICKS > DOOR_TICKS) ? STEP_TICKS : DOOR_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0]   DOOR_LAST = CNT_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  logic [1:0]            state, state_nx;
  logic [FLOOR_W-1:0]    floor_nx;
  logic [NUM_FLOORS-1:0] pending_nx;
  logic                  dir_up, dir_nx;
  logic [CNT_W-1:0]      step_cnt, step_nx;
  logic [CNT_W-1:0]      door_cnt, door_nx;
  // Set for exactly the one cycle after the cab lands on a new floor.
  logic                  arrived, arrived_nx;

  logic [NUM_FLOORS-1:0] floor_mask;
  logic [NUM_FLOORS-1:0] look;
  logic [NUM_FLOORS-1:0] serve;
  logic                  above, below, ahead, behind;
  logic                  here_pend, here_call;
  logic                  go_step;

  // IDLE decides on registered calls plus this cycle's call_in, so a fresh
  // call is acted on without first waiting for it to be latched.
  always_comb begin
    floor_mask = NUM_FLOORS'(1) << current_floor;
    look       = (state == S_IDLE) ? (pending | call_in) : pending;
    here_pend  = |(pending & floor_mask);
    here_call  = |(call_in & floor_mask);
    above      = 1'b0;
    below      = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (look[i] && (FLOOR_W'(i) > current_floor)) above = 1'b1;
      if (look[i] && (FLOOR_W'(i) < current_floor)) below = 1'b1;
    end
    ahead  = dir_up ? above : below;
    behind = dir_up ? below : above;
  end

  always_comb begin
    state_nx   = state;
    floor_nx   = current_floor;
    dir_nx     = dir_up;
    step_nx    = step_cnt;
    door_nx    = door_cnt;
    arrived_nx = 1'b0;
    go_step    = 1'b0;

    case (state)
      S_IDLE: begin
        if (here_pend || here_call) begin
          state_nx = S_DOOR;
          door_nx  = '0;
        end else if (ahead) begin
          state_nx = dir_up ? S_UP : S_DOWN;
          step_nx  = '0;
        end else if (behind) begin
          state_nx = dir_up ? S_DOWN : S_UP;
          dir_nx   = ~dir_up;
          step_nx  = '0;
        end
      end

      S_UP, S_DOWN: begin
        go_step = 1'b1;
        // The landing cycle doubles as the first cycle of the next step
        // when the cab keeps going, so continuous travel is STEP_TICKS/floor.
        if (arrived) begin
          if (here_pend) begin
            state_nx = S_DOOR;
            door_nx  = '0;
            go_step  = 1'b0;
          end else if (!ahead) begin
            state_nx = S_IDLE;
            step_nx  = '0;
            go_step  = 1'b0;
          end
        end
        if (go_step) begin
          if (step_cnt == STEP_LAST) begin
            step_nx    = '0;
            arrived_nx = 1'b1;
            // Range guard: the cab never steps past either end shaft.
            if (state == S_UP && current_floor != TOP_FLOOR) begin
              floor_nx = current_floor + 1'b1;
            end else if (state == S_DOWN && current_floor != '0) begin
              floor_nx = current_floor - 1'b1;
            end
          end else begin
            step_nx = step_cnt + 1'b1;
          end
        end
      end

      default: begin // S_DOOR
        if (here_call) begin
          door_nx = '0;
        end else if (door_cnt == DOOR_LAST) begin
          door_nx = '0;
          if (ahead) begin
            state_nx = dir_up ? S_UP : S_DOWN;
            step_nx  = '0;
          end else if (behind) begin
            state_nx = dir_up ? S_DOWN : S_UP;
            dir_nx   = ~dir_up;
            step_nx  = '0;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          door_nx = door_cnt + 1'b1;
        end
      end
    endcase

    // A call for the floor whose door is (or is about to be) open is already
    // satisfied, so it is masked out rather than latched.
    serve      = ((state == S_DOOR) || (state_nx == S_DOOR)) ? floor_mask : '0;
    pending_nx = (pending | call_in) & ~serve;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      current_floor <= '0;
      pending       <= '0;
      dir_up        <= 1'b1;
      step_cnt      <= '0;
      door_cnt      <= '0;
      arrived       <= 1'b0;
    end else begin
      state         <= state_nx;
      current_floor <= floor_nx;
      pending       <= pending_nx;
      dir_up        <= dir_nx;
      step_cnt      <= step_nx;
      door_cnt      <= door_nx;
      arrived       <= arrived_nx;
    end
  end

  assign idle        = (state == S_IDLE);
  assign moving_up   = (state == S_UP);
  assign moving_down = (state == S_DOWN);
  assign door_open   = (state == S_DOOR);

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Purpose: self-checking bench for elevator_scan_controller (8 floors, 4-cycle steps, 3-cycle door).
// Latency: outputs sampled on the falling edge; inputs driven on the falling edge.
// Backpressure: not applicable; the bench drives call_in freely.
module tb_elevator_scan_controller;

  localparam int NF = 8;
  localparam int ST = 4;
  localparam int DT = 3;

  logic          clk;
  logic          rst;
  logic [NF-1:0] call_in;
  logic [3:0]    current_floor;
  logic [NF-1:0] pending;
  logic          moving_up, moving_down, door_open, idle;

  elevator_scan_controller #(
    .NUM_FLOORS(NF), .FLOOR_W(4), .STEP_TICKS(ST), .DOOR_TICKS(DT)
  ) dut (
    .clk(clk), .rst(rst), .call_in(call_in), .current_floor(current_floor),
    .pending(pending), .moving_up(moving_up), .moving_down(moving_down),
    .door_open(door_open), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] dut_snap;
  assign dut_snap = {current_floor, pending, idle, moving_up, moving_down, door_open};

  // ---------------- reference model: countdown timers over plain integers ----------------
  typedef enum int {M_IDLE, M_UP, M_DOWN, M_DOOR} mmode_t;
  int      m_floor;
  bit [7:0] m_req;
  bit      m_dir;
  mmode_t  m_mode;
  int      m_left;
  bit      m_arr;

  function automatic bit beyond(input bit up, input bit [7:0] r, input int f);
    for (int i = 0; i < NF; i++)
      if (r[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] exp_snap();
    return {4'(m_floor), m_req, m_mode == M_IDLE, m_mode == M_UP,
            m_mode == M_DOWN, m_mode == M_DOOR};
  endfunction

  task automatic m_reset();
    m_floor = 0; m_req = '0; m_dir = 1'b1; m_mode = M_IDLE; m_left = 0; m_arr = 1'b0;
  endtask

  task automatic m_begin_move(input bit [7:0] r, input int f);
    if (beyond(m_dir, r, f)) begin
      m_mode = m_dir ? M_UP : M_DOWN; m_left = ST;
    end else if (beyond(!m_dir, r, f)) begin
      m_dir = !m_dir; m_mode = m_dir ? M_UP : M_DOWN; m_left = ST;
    end else begin
      m_mode = M_IDLE;
    end
  endtask

  task automatic m_step(input bit [7:0] c);
    mmode_t old_mode;
    int     f;
    bit     arr, travel;
    old_mode = m_mode; f = m_floor; arr = m_arr; m_arr = 1'b0;
    case (old_mode)
      M_IDLE: begin
        if (m_req[f] || c[f]) begin
          m_mode = M_DOOR; m_left = DT;
        end else begin
          m_begin_move(m_req | c, f);
        end
      end
      M_UP, M_DOWN: begin
        travel = 1'b1;
        if (arr) begin
          if (m_req[f]) begin
            m_mode = M_DOOR; m_left = DT; travel = 1'b0;
          end else if (!beyond(m_dir, m_req, f)) begin
            m_mode = M_IDLE; travel = 1'b0;
          end
        end
        if (travel) begin
          m_left--;
          if (m_left == 0) begin
            if (old_mode == M_UP && f < NF - 1) m_floor = f + 1;
            if (old_mode == M_DOWN && f > 0) m_floor = f - 1;
            m_left = ST; m_arr = 1'b1;
          end
        end
      end
      default: begin
        if (c[f]) begin
          m_left = DT;
        end else begin
          m_left--;
          if (m_left == 0) m_begin_move(m_req, f);
        end
      end
    endcase
    m_req = m_req | c;
    if (old_mode == M_DOOR || m_mode == M_DOOR) m_req[f] = 1'b0;
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic tick(input bit [7:0] c);
    call_in = c;
    m_step(c);
    @(posedge clk);
    @(negedge clk);
  endtask

  // call_in is held high through reset to show it is ignored.
  task automatic do_reset();
    rst = 1'b1; call_in = 8'hFF;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; call_in = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_cmp++; if ({moving_up, moving_down, door_open} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {moving_up, moving_down, door_open}); end
    n_cmp++; if (current_floor !== 4'd0) begin n_bad++; $display("FAIL reset_floor: got %0d want 0", current_floor); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL reset_pending: got %h want 00", pending); end
  endtask

  task automatic test_single_call();
    int chg[$];
    int doors, prev;
    bit done;
    do_reset();
    tick(8'h08);
    prev = 0; doors = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      n_cmp++; if (dut_snap !== exp_snap()) begin
        n_bad++; $display("FAIL single_call cyc %0d: got %h want %h", i, dut_snap, exp_snap()); end
      if (int'(current_floor) != prev) begin chg.push_back(i); prev = int'(current_floor); end
      if (door_open) doors++;
      if (idle && doors > 0) done = 1'b1; else tick(8'h00);
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL single_call_timeout: got busy want idle"); end
    n_cmp++; if (chg.size() != 3 || chg[0] != 4 || chg[1] != 8 || chg[2] != 12) begin
      n_bad++; $display("FAIL single_call_spacing: got %0d changes first at %0d want 3 at 4/8/12",
                        chg.size(), (chg.size() > 0) ? chg[0] : -1); end
    n_cmp++; if (doors != DT) begin n_bad++; $display("FAIL single_call_door: got %0d want %0d", doors, DT); end
    n_cmp++; if (current_floor !== 4'd3 || pending !== 8'h00) begin
      n_bad++; $display("FAIL single_call_end: got floor %0d pend %h want 3 00", current_floor, pending); end
  endtask

  task automatic test_call_here();
    int doors;
    do_reset();
    tick(8'h01);
    n_cmp++; if (door_open !== 1'b1) begin n_bad++; $display("FAIL here_open: got %b want 1", door_open); end
    doors = 0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (dut_snap !== exp_snap()) begin
        n_bad++; $display("FAIL here cyc %0d: got %h want %h", i, dut_snap, exp_snap()); end
      n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL here_pending: got %h want 00", pending); end
      if (door_open) doors++;
      tick(8'h00);
    end
    n_cmp++; if (doors != DT || idle !== 1'b1) begin
      n_bad++; $display("FAIL here_door: got %0d idle %b want %0d idle 1", doors, idle, DT); end
  endtask

  task automatic test_sweep();
    int stops[$];
    bit injected, prev_door, done;
    bit [7:0] c;
    do_reset();
    tick(8'h20);
    injected = 1'b0; prev_door = 1'b0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      n_cmp++; if (dut_snap !== exp_snap()) begin
        n_bad++; $display("FAIL sweep cyc %0d: got %h want %h", i, dut_snap, exp_snap()); end
      if (door_open && !prev_door) stops.push_back(int'(current_floor));
      prev_door = door_open;
      c = 8'h00;
      if (!injected && current_floor == 4'd1) begin c = 8'h06; injected = 1'b1; end
      if (idle && stops.size() >= 3) done = 1'b1; else tick(c);
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL sweep_timeout: got busy want idle"); end
    n_cmp++; if (stops.size() != 3 || stops[0] != 2 || stops[1] != 5 || stops[2] != 1) begin
      n_bad++; $display("FAIL sweep_order: got %0d stops first %0d want 2,5,1",
                        stops.size(), (stops.size() > 0) ? stops[0] : -1); end
    n_cmp++; if (current_floor !== 4'd1 || pending !== 8'h00) begin
      n_bad++; $display("FAIL sweep_end: got floor %0d pend %h want 1 00", current_floor, pending); end
    // Direction left pointing down: equidistant calls either side go down first.
    tick(8'h05);
    n_cmp++; if (moving_down !== 1'b1) begin
      n_bad++; $display("FAIL sweep_dir: got moving_down %b want 1", moving_down); end
  endtask

  task automatic test_door_hold();
    int after;
    bit reached;
    do_reset();
    tick(8'h10);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      n_cmp++; if (dut_snap !== exp_snap()) begin
        n_bad++; $display("FAIL hold_travel cyc %0d: got %h want %h", i, dut_snap, exp_snap()); end
      if (door_open) reached = 1'b1; else tick(8'h00);
    end
    n_cmp++; if (!reached || current_floor !== 4'd4) begin
      n_bad++; $display("FAIL hold_reach: got floor %0d open %b want 4 1", current_floor, door_open); end
    for (int i = 0; i < 5; i++) begin
      tick(8'h10);
      n_cmp++; if (door_open !== 1'b1 || dut_snap !== exp_snap()) begin
        n_bad++; $display("FAIL hold_open cyc %0d: got %h want %h", i, dut_snap, exp_snap()); end
    end
    after = 0;
    for (int i = 0; i < 20 && door_open; i++) begin
      after++;
      tick(8'h00);
    end
    n_cmp++; if (after != DT || idle !== 1'b1) begin
      n_bad++; $display("FAIL hold_release: got %0d open cycles idle %b want %0d idle 1", after, idle, DT); end
  endtask

  task automatic test_top();
    int stops[$];
    int maxf;
    bit prev_door, done, went_up;
    do_reset();
    tick(8'h80);
    done = 1'b0; maxf = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (int'(current_floor) > maxf) maxf = int'(current_floor);
      if (idle && current_floor == 4'd7) done = 1'b1; else tick(8'h00);
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL top_reach: got floor %0d want 7 idle", current_floor); end
    tick(8'h81);
    done = 1'b0; prev_door = 1'b0; went_up = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      n_cmp++; if (dut_snap !== exp_snap()) begin
        n_bad++; $display("FAIL top cyc %0d: got %h want %h", i, dut_snap, exp_snap()); end
      if (int'(current_floor) > maxf) maxf = int'(current_floor);
      if (moving_up) went_up = 1'b1;
      if (door_open && !prev_door) stops.push_back(int'(current_floor));
      prev_door = door_open;
      if (idle && stops.size() >= 2) done = 1'b1; else tick(8'h00);
    end
    n_cmp++; if (stops.size() != 2 || stops[0] != 7 || stops[1] != 0 || went_up) begin
      n_bad++; $display("FAIL top_order: got %0d stops first %0d up %b want 7,0 up 0",
                        stops.size(), (stops.size() > 0) ? stops[0] : -1, went_up); end
    n_cmp++; if (maxf > 7) begin n_bad++; $display("FAIL top_bound: got max floor %0d want <=7", maxf); end
  endtask

  task automatic test_reset_mid();
    bit done;
    do_reset();
    tick(8'h40);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++)
      if (idle && current_floor == 4'd6) done = 1'b1; else tick(8'h00);
    tick(8'h09);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      n_cmp++; if (dut_snap !== exp_snap()) begin
        n_bad++; $display("FAIL mid cyc %0d: got %h want %h", i, dut_snap, exp_snap()); end
      if (moving_down && current_floor == 4'd5) done = 1'b1; else tick(8'h00);
    end
    tick(8'h00);
    tick(8'h00);
    n_cmp++; if (!done || moving_down !== 1'b1 || pending !== 8'h09) begin
      n_bad++; $display("FAIL mid_setup: got down %b pend %h want 1 09", moving_down, pending); end
    do_reset();
    n_cmp++; if (dut_snap !== 16'h0008) begin
      n_bad++; $display("FAIL mid_reset: got %h want 0008", dut_snap); end
    tick(8'h00);
    n_cmp++; if (dut_snap !== 16'h0008) begin
      n_bad++; $display("FAIL mid_after: got %h want 0008", dut_snap); end
  endtask

  task automatic test_random();
    bit [7:0] c;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      n_cmp++; if (dut_snap !== exp_snap()) begin
        n_bad++; $display("FAIL random cyc %0d: got %h want %h", i, dut_snap, exp_snap()); end
      n_cmp++; if ($countones({idle, moving_up, moving_down, door_open}) != 1 || current_floor > 4'd7) begin
        n_bad++; $display("FAIL random_inv cyc %0d: got flags %b floor %0d want one-hot <=7", i,
                          {idle, moving_up, moving_down, door_open}, current_floor); end
      c = 8'h00;
      if ($urandom_range(0, 7) == 0) c[$urandom_range(0, 7)] = 1'b1;
      if ($urandom_range(0, 29) == 0) c = 8'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset(); else tick(c);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; call_in = '0;
    m_reset();
    test_reset();
    test_single_call();
    test_call_here();
    test_sweep();
    test_door_hold();
    test_top();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
